bw_div: RTL

- Iterative signed two's-complement divider; it is the inverse operation of the team's combinational Baugh-Wooley signed multiplier.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor.
- Uses restoring division on magnitudes, one quotient bit per clock, then applies sign correction.
- Sits beside the multiplier in the user project area, driven by a start/done handshake from the control logic.

---
 rtl/bw_arith_pkg.sv | 31 +++
 rtl/bw_div_step.sv | 29 ++
 rtl/bw_div.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bw_arith_pkg.sv
// Shared arithmetic package for the Baugh-Wooley multiplier / divider pair.
// Holds the divider state encoding, the default operand width and a
// two's-complement negate/abs helper. The helpers work on 64-bit containers;
// callers zero-extend a W-bit value in and truncate the result back to W bits.
// Negation modulo 2^64 truncated to W bits is exact negation modulo 2^W.
package bw_arith_pkg;

  localparam int unsigned BW_DEF_WIDTH = 8;
  localparam int unsigned BW_MAX_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } bw_div_state_t;

  function automatic logic [BW_MAX_WIDTH-1:0] tc_neg(input logic [BW_MAX_WIDTH-1:0] v);
    return ~v + 64'd1;
  endfunction

  // |v| where v holds a w-bit signed value in its low bits (upper bits zero).
  function automatic logic [BW_MAX_WIDTH-1:0] tc_abs(input logic [BW_MAX_WIDTH-1:0] v,
                                                     input int unsigned w);
    logic [5:0] sidx;
    sidx = 6'(w - 1);
    return v[sidx] ? tc_neg(v) : v;
  endfunction

endpackage

// File: rtl/bw_div_step.sv
// One restoring-division step.
// Ports:
//   i_rem  [WIDTH:0]   partial remainder before this step
//   i_bit              next dividend magnitude bit (MSB first)
//   i_dvs  [WIDTH-1:0] divisor magnitude
//   o_rem  [WIDTH:0]   partial remainder after this step
//   o_qbit             quotient bit produced by this step
module bw_div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // The partial remainder is always below the divisor magnitude, so the
  // shifted value never needs the bit that falls off the top.
  assign w_shift = (i_rem << 1) | {{WIDTH{1'b0}}, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  // MSB of the WIDTH+1-bit trial subtract is the borrow.
  assign o_qbit  = ~w_diff[WIDTH];
  assign o_rem   = o_qbit ? w_diff : w_shift;

endmodule

// File: rtl/bw_div.sv
// Iterative signed two's-complement divider (restoring, one bit per clock).
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   start_i                  request, sampled only in IDLE
//   dividend_i, divisor_i    signed operands, captured on accept
//   busy_o, done_o           busy from PREP through DONE; done one-cycle pulse
//   quotient_o, remainder_o  signed results, held until the next FIX
//   div_zero_o, overflow_o   special-case flags, held with the results
module bw_div
  import bw_arith_pkg::*;
#(
  parameter int unsigned WIDTH = BW_DEF_WIDTH
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             overflow_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  bw_div_state_t r_state, w_next;

  logic [WIDTH-1:0] r_dvd, r_dvs;
  logic [WIDTH-1:0] r_amag, r_bmag, r_qmag;
  logic [WIDTH:0]   r_rem;
  logic             r_neg_q, r_neg_r;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_quot, r_remo;
  logic             r_dz, r_ov;

  logic [WIDTH:0]   w_rem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_abs_dvd, w_abs_dvs, w_qneg, w_rneg;
  logic             w_last;
  logic             w_dvs_zero, w_ovf;

  assign w_abs_dvd  = WIDTH'(tc_abs(64'(r_dvd), WIDTH));
  assign w_abs_dvs  = WIDTH'(tc_abs(64'(r_dvs), WIDTH));
  assign w_qneg     = WIDTH'(tc_neg(64'(r_qmag)));
  assign w_rneg     = WIDTH'(tc_neg(64'(r_rem[WIDTH-1:0])));
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_dvs_zero = (r_dvs == '0);
  assign w_ovf      = (r_dvd == {1'b1, {(WIDTH-1){1'b0}}}) && (r_dvs == '1);

  bw_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_amag[WIDTH-1]),
    .i_dvs  (r_bmag),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy_o = 1'b1;
    done_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = PREP;
      end
      PREP: w_next = CALC;
      CALC: if (w_last) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_amag  <= '0;
      r_bmag  <= '0;
      r_qmag  <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_dvd <= dividend_i;
            r_dvs <= divisor_i;
          end
        end
        PREP: begin
          r_amag  <= w_abs_dvd;
          r_bmag  <= w_abs_dvs;
          r_neg_q <= r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1];
          r_neg_r <= r_dvd[WIDTH-1];
          r_rem   <= '0;
          r_qmag  <= '0;
          r_cnt   <= '0;
        end
        CALC: begin
          r_rem  <= w_rem_next;
          r_qmag <= {r_qmag[WIDTH-2:0], w_qbit};
          r_amag <= r_amag << 1;
          r_cnt  <= r_cnt + 1'b1;
        end
        FIX: begin
          if (w_dvs_zero) begin
            r_quot <= '1;
            r_remo <= r_dvd;
            r_dz   <= 1'b1;
            r_ov   <= 1'b0;
          end else if (w_ovf) begin
            r_quot <= r_dvd;
            r_remo <= '0;
            r_dz   <= 1'b0;
            r_ov   <= 1'b1;
          end else begin
            r_quot <= r_neg_q ? w_qneg : r_qmag;
            r_remo <= r_neg_r ? w_rneg : r_rem[WIDTH-1:0];
            r_dz   <= 1'b0;
            r_ov   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_o  = r_quot;
  assign remainder_o = r_remo;
  assign div_zero_o  = r_dz;
  assign overflow_o  = r_ov;

endmodule
